fc_seq_ctrl: RTL and testbench

Sequencer for the fully-connected layer's 1-D systolic chain of `N_PE` FC processing elements. The chain is ifmap-stationary: each PE holds one ifmap byte, weights stream in, and psums ripple from PE 0 to PE `N_PE-1`.

This block loads the ifmap vector into the chain and streams one weight row per output neuron, applying per-lane skew. It captures each finished psum from the chain tail and tags it with its output-neuron index. It sits between the ifmap/weight SRAM buffers and the PE chain.

---
 rtl/fc_pkg.sv | 16 +
 rtl/fc_weight_skew.sv | 49 ++++
 rtl/fc_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fc_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer sequencer.
package fc_pkg;

    localparam int N_PE_DEF  = 8;   // PEs in the systolic chain
    localparam int OUT_W_DEF = 8;   // width of output-neuron count / index
    localparam int AW_DEF    = 8;   // buffer address width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fc_weight_skew.sv
// Triangular weight skew: lane k of a returned weight row reaches PE k
// k cycles later. Lane 0 passes straight through. Each delay slot
// carries a valid bit, and a slot without a valid row drives 0, so idle
// PEs add nothing to the psum passing through them.
module fc_weight_skew
    import fc_pkg::*;
#(
    parameter int N_PE = N_PE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [8*N_PE-1:0] row_i,
    output logic [8*N_PE-1:0] weight_o
);

    assign weight_o[7:0] = valid_i ? row_i[7:0] : 8'd0;

    for (genvar k = 1; k < N_PE; k++) begin : g_lane
        logic [7:0] dly_q [k];
        logic       vld_q [k];

        // Lane k: k-deep shift register of weight byte and its valid bit.
        always_ff @(posedge clk) begin
            if (rst) begin
                // NOTE: these slots are individual flops, not a RAM, so they
                // are cleared explicitly; a reset mid-row must not leave a
                // stale valid weight heading for a PE.
                for (int i = 0; i < k; i++) begin
                    dly_q[i] <= 8'd0;
                    vld_q[i] <= 1'b0;
                end
            end else begin
                // NOTE: non-blocking assignments make every stage take its
                // neighbour's old value, so the chain shifts by one slot per
                // clock regardless of statement order.
                dly_q[0] <= row_i[8*k +: 8];
                vld_q[0] <= valid_i;
                for (int i = 1; i < k; i++) begin
                    dly_q[i] <= dly_q[i-1];
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        assign weight_o[8*k +: 8] = vld_q[k-1] ? dly_q[k-1] : 8'd0;
    end

endmodule

// File: rtl/fc_seq_ctrl.sv
// Sequencer for the ifmap-stationary FC PE chain: loads the ifmap vector
// into the chain (reverse address order, so PE k ends up with ifmap[k]),
// streams one weight row per output neuron through the skew, and captures
// each finished psum from the chain tail tagged with its neuron index.
module fc_seq_ctrl
    import fc_pkg::*;
#(
    parameter int N_PE  = N_PE_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OUT_W-1:0]  cfg_num_out,
    output logic              busy,
    output logic              done,
    output logic              ifbuf_rd_en,
    output logic [AW-1:0]     ifbuf_rd_addr,
    input  logic [7:0]        ifbuf_rd_data,
    output logic              pe_load,
    output logic [7:0]        pe_ifmap,
    output logic              wbuf_rd_en,
    output logic [AW-1:0]     wbuf_rd_addr,
    input  logic [8*N_PE-1:0] wbuf_rd_data,
    output logic [8*N_PE-1:0] pe_weight,
    input  logic [7:0]        chain_psum,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic [OUT_W-1:0]  out_idx
);

    state_e           state_q;
    logic [OUT_W-1:0] num_out_q;
    logic [OUT_W-1:0] rd_row_q;
    logic [OUT_W-1:0] out_cnt_q;
    logic [OUT_W-1:0] out_idx_q;
    logic             busy_q;
    logic             done_q;
    logic             ifbuf_rd_en_q;
    logic [AW-1:0]    ifbuf_rd_addr_q;
    logic             pe_load_q;
    logic             wbuf_rd_en_q;
    logic [AW-1:0]    wbuf_rd_addr_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    // tag_q[0] marks a weight row arriving from the buffer this cycle;
    // tag_q[N_PE] marks its finished psum leaving the chain tail.
    logic [N_PE:0]    tag_q;
    logic             last_out;

    assign last_out = out_valid_q && (out_idx_q == num_out_q - OUT_W'(1));

    // Control FSM with registered buffer-read, load and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            num_out_q       <= '0;
            rd_row_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            ifbuf_rd_en_q   <= 1'b0;
            ifbuf_rd_addr_q <= '0;
            pe_load_q       <= 1'b0;
            wbuf_rd_en_q    <= 1'b0;
            wbuf_rd_addr_q  <= '0;
        end else begin
            done_q          <= 1'b0;
            ifbuf_rd_en_q   <= 1'b0;
            ifbuf_rd_addr_q <= '0;
            wbuf_rd_en_q    <= 1'b0;
            wbuf_rd_addr_q  <= '0;
            // The ifmap byte arrives one cycle after its read.
            pe_load_q       <= ifbuf_rd_en_q;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_out_q <= cfg_num_out;
                        busy_q    <= 1'b1;
                        if (cfg_num_out == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q         <= ST_LOAD;
                            ifbuf_rd_en_q   <= 1'b1;
                            ifbuf_rd_addr_q <= AW'(N_PE - 1);
                        end
                    end
                end
                ST_LOAD: begin
                    if (ifbuf_rd_addr_q == '0) begin
                        // First weight read overlaps the final ifmap shift.
                        state_q        <= ST_COMPUTE;
                        wbuf_rd_en_q   <= 1'b1;
                        wbuf_rd_addr_q <= '0;
                        rd_row_q       <= '0;
                    end else begin
                        ifbuf_rd_en_q   <= 1'b1;
                        ifbuf_rd_addr_q <= ifbuf_rd_addr_q - AW'(1);
                    end
                end
                ST_COMPUTE: begin
                    if (rd_row_q == num_out_q - OUT_W'(1)) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        wbuf_rd_en_q   <= 1'b1;
                        rd_row_q       <= rd_row_q + OUT_W'(1);
                        wbuf_rd_addr_q <= AW'(rd_row_q + OUT_W'(1));
                    end
                end
                ST_DRAIN: begin
                    if (last_out) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Valid tag follows each row through buffer, skew and chain; the
    // output register captures the chain tail when the tag emerges.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_idx_q   <= '0;
            out_cnt_q   <= '0;
        end else begin
            tag_q       <= {tag_q[N_PE-1:0], wbuf_rd_en_q};
            out_valid_q <= tag_q[N_PE];
            out_data_q  <= tag_q[N_PE] ? chain_psum : 8'd0;
            if (tag_q[N_PE]) begin
                out_idx_q <= out_cnt_q;
                out_cnt_q <= out_cnt_q + OUT_W'(1);
            end else begin
                out_idx_q <= '0;
                if (state_q == ST_IDLE) begin
                    out_cnt_q <= '0;
                end
            end
        end
    end

    fc_weight_skew #(
        .N_PE (N_PE)
    ) u_skew (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (tag_q[0]),
        .row_i    (wbuf_rd_data),
        .weight_o (pe_weight)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign ifbuf_rd_en   = ifbuf_rd_en_q;
    assign ifbuf_rd_addr = ifbuf_rd_addr_q;
    assign pe_load       = pe_load_q;
    assign pe_ifmap      = pe_load_q ? ifbuf_rd_data : 8'd0;
    assign wbuf_rd_en    = wbuf_rd_en_q;
    assign wbuf_rd_addr  = wbuf_rd_addr_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_idx       = out_idx_q;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Testbench for fc_seq_ctrl: buffer and PE-chain models around the DUT,
// table-driven runs, randomized runs against a dot-product reference,
// and hand-written start-while-busy and mid-run reset sequences.
module tb_fc_seq_ctrl;

    localparam int N    = 4;
    localparam int MAXR = 16;

    logic           clk;
    logic           rst;
    logic           start;
    logic [7:0]     cfg_num_out;
    logic           busy;
    logic           done;
    logic           ifbuf_rd_en;
    logic [7:0]     ifbuf_rd_addr;
    logic [7:0]     ifbuf_rd_data;
    logic           pe_load;
    logic [7:0]     pe_ifmap;
    logic           wbuf_rd_en;
    logic [7:0]     wbuf_rd_addr;
    logic [8*N-1:0] wbuf_rd_data;
    logic [8*N-1:0] pe_weight;
    logic [7:0]     chain_psum;
    logic           out_valid;
    logic [7:0]     out_data;
    logic [7:0]     out_idx;

    fc_seq_ctrl #(.N_PE(N), .OUT_W(8), .AW(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_num_out   (cfg_num_out),
        .busy          (busy),
        .done          (done),
        .ifbuf_rd_en   (ifbuf_rd_en),
        .ifbuf_rd_addr (ifbuf_rd_addr),
        .ifbuf_rd_data (ifbuf_rd_data),
        .pe_load       (pe_load),
        .pe_ifmap      (pe_ifmap),
        .wbuf_rd_en    (wbuf_rd_en),
        .wbuf_rd_addr  (wbuf_rd_addr),
        .wbuf_rd_data  (wbuf_rd_data),
        .pe_weight     (pe_weight),
        .chain_psum    (chain_psum),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_idx       (out_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffers: one-cycle read latency.
    logic [7:0]     ifmap_mem [256];
    logic [8*N-1:0] wmem      [256];

    always @(posedge clk) begin
        if (ifbuf_rd_en) ifbuf_rd_data <= ifmap_mem[ifbuf_rd_addr];
        if (wbuf_rd_en)  wbuf_rd_data  <= wmem[wbuf_rd_addr];
    end

    // PE chain: ifmap shifts in at PE 0; psum_k = psum_{k-1} + w_k * if_k.
    logic [7:0] pe_if [N];
    logic [7:0] pe_ps [N];
    assign chain_psum = pe_ps[N-1];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                pe_if[k] <= 8'd0;
                pe_ps[k] <= 8'd0;
            end
        end else begin
            if (pe_load) begin
                pe_if[0] <= pe_ifmap;
                for (int k = 1; k < N; k++) pe_if[k] <= pe_if[k-1];
            end
            for (int k = 0; k < N; k++)
                pe_ps[k] <= ((k == 0) ? 8'd0 : pe_ps[k-1]) + pe_weight[8*k +: 8] * pe_if[k];
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Current test case: ifmap, weight rows and expected results.
    logic [7:0] cur_ifm [N];
    logic [7:0] cur_w   [MAXR][N];
    logic [7:0] exp_d   [MAXR];

    task automatic load_mem(input int m);
        for (int k = 0; k < N; k++) ifmap_mem[k] = cur_ifm[k];
        for (int j = 0; j < m; j++)
            for (int k = 0; k < N; k++) wmem[j][8*k +: 8] = cur_w[j][k];
    endtask

    // Reference: each result is the ifmap/row dot product mod 256.
    task automatic model_results(input int m);
        for (int j = 0; j < m; j++) begin
            int sum = 0;
            for (int k = 0; k < N; k++) sum += int'(cur_ifm[k]) * int'(cur_w[j][k]);
            exp_d[j] = 8'(sum % 256);
        end
    endtask

    // One complete job; optional second start inj_at cycles after the first.
    task automatic run_case(input string tag, input int m, input int inj_at);
        int s, exp_done, done_cnt, done_cyc, busy_err;
        int if_rd, if_err, w_rd, w_err, ld_cnt;
        int o_cyc [$];
        int o_dat [$];
        int o_idx [$];
        done_cnt = 0; done_cyc = -1; busy_err = 0;
        if_rd = 0; if_err = 0; w_rd = 0; w_err = 0; ld_cnt = 0;
        load_mem(m);
        start       = 1'b1;
        cfg_num_out = 8'(m);
        s           = cyc;
        exp_done    = (m == 0) ? s + 1 : s + 2*N + m + 3;
        for (int i = 0; i < exp_done - s + 4; i++) begin
            @(negedge clk);
            start       = 1'b0;
            cfg_num_out = 8'hA5;
            if (inj_at > 0 && cyc == s + inj_at) begin
                start       = 1'b1;
                cfg_num_out = 8'd5;
            end
            if (out_valid) begin
                o_cyc.push_back(cyc - s);
                o_dat.push_back(int'(out_data));
                o_idx.push_back(int'(out_idx));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy != (cyc >= s + 1 && cyc <= exp_done)) busy_err++;
            if (ifbuf_rd_en) begin
                if (ifbuf_rd_addr != 8'(N - 1 - if_rd)) if_err++;
                if_rd++;
            end
            if (wbuf_rd_en) begin
                if (wbuf_rd_addr != 8'(w_rd)) w_err++;
                w_rd++;
            end
            if (pe_load) ld_cnt++;
        end
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_cycle"}, done_cyc - s, exp_done - s);
        check({tag, " result_count"}, o_cyc.size(), m);
        for (int j = 0; j < o_cyc.size() && j < m; j++) begin
            check($sformatf("%s data[%0d]", tag, j), o_dat[j], int'(exp_d[j]));
            check($sformatf("%s idx[%0d]", tag, j), o_idx[j], j);
            check($sformatf("%s cycle[%0d]", tag, j), o_cyc[j], 2*N + 3 + j);
        end
        check({tag, " busy_window_errors"}, busy_err, 0);
        check({tag, " ifbuf_reads"}, if_rd, (m == 0) ? 0 : N);
        check({tag, " ifbuf_addr_errors"}, if_err, 0);
        check({tag, " pe_loads"}, ld_cnt, (m == 0) ? 0 : N);
        check({tag, " wbuf_reads"}, w_rd, m);
        check({tag, " wbuf_addr_errors"}, w_err, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " ctrl_outputs"},
              {busy, done, ifbuf_rd_en, ifbuf_rd_addr, pe_load, pe_ifmap, wbuf_rd_en, wbuf_rd_addr}, 0);
        check({tag, " data_outputs"}, {pe_weight, out_valid, out_data, out_idx}, 0);
    endtask

    typedef struct {
        string               name;
        logic [N-1:0][7:0]   ifm;
        logic [2:0][N-1:0][7:0] w;
        int                  num_out;
        logic [2:0][7:0]     exp_d;
    } vec_t;

    function automatic logic [N-1:0][7:0] row4(input int a, input int b, input int c, input int d);
        logic [N-1:0][7:0] r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
        return r;
    endfunction

    vec_t tbl [5];

    task automatic use_vec(input int i);
        for (int k = 0; k < N; k++) cur_ifm[k] = tbl[i].ifm[k];
        for (int j = 0; j < 3; j++) begin
            exp_d[j] = tbl[i].exp_d[j];
            for (int k = 0; k < N; k++) cur_w[j][k] = tbl[i].w[j][k];
        end
    endtask

    initial begin
        int stray_valid, stray_done, stray_busy;

        tbl[0] = '{"basic", row4(1,2,3,4), '{row4(0,0,0,0), row4(0,0,0,0), row4(1,1,1,1)}, 1,
                   '{8'd0, 8'd0, 8'd10}};
        tbl[1] = '{"multi", row4(1,2,3,4), '{row4(2,2,2,2), row4(0,0,0,2), row4(1,0,0,0)}, 3,
                   '{8'd20, 8'd8, 8'd1}};
        tbl[2] = '{"wrap", row4(255,255,255,255), '{row4(0,0,0,0), row4(0,0,0,0), row4(255,255,255,255)}, 1,
                   '{8'd0, 8'd0, 8'd4}};
        tbl[3] = '{"two", row4(10,20,30,40), '{row4(0,0,0,0), row4(3,0,1,0), row4(1,2,3,4)}, 2,
                   '{8'd0, 8'd60, 8'd44}};
        tbl[4] = '{"zero", row4(9,9,9,9), '{row4(0,0,0,0), row4(0,0,0,0), row4(0,0,0,0)}, 0,
                   '{8'd0, 8'd0, 8'd0}};

        for (int a = 0; a < 256; a++) begin
            ifmap_mem[a] = 8'd0;
            wmem[a]      = '0;
        end
        rst = 1'b1; start = 1'b0; cfg_num_out = 8'd0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table-driven runs.
        for (int i = 0; i < 5; i++) begin
            use_vec(i);
            run_case(tbl[i].name, tbl[i].num_out, 0);
        end

        // Randomized runs against the dot-product reference.
        for (int r = 0; r < 6; r++) begin
            int m;
            m = $urandom_range(1, 10);
            for (int k = 0; k < N; k++) cur_ifm[k] = 8'($urandom);
            for (int j = 0; j < m; j++)
                for (int k = 0; k < N; k++) cur_w[j][k] = 8'($urandom);
            model_results(m);
            run_case($sformatf("rand%0d", r), m, 0);
        end

        // Second start during COMPUTE must be ignored.
        use_vec(3);
        model_results(2);
        run_case("start_busy", 2, N + 2);

        // Reset asserted during COMPUTE.
        use_vec(1);
        load_mem(3);
        start = 1'b1; cfg_num_out = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_outputs_zero("midrst");
        stray_valid = 0; stray_done = 0; stray_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stray_valid++;
            if (done)      stray_done++;
            if (busy)      stray_busy++;
        end
        check("midrst stray_out_valid", stray_valid, 0);
        check("midrst stray_done", stray_done, 0);
        check("midrst stray_busy", stray_busy, 0);

        // Fresh run after the reset reproduces the basic result.
        use_vec(0);
        run_case("after_rst", 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
